// File: rtl/seq_dualrail_tx.sv
// Dual-rail serial transmitter: one word in over val/rdy, MSB-first symbols out as CODE+SPACE pairs, optional odd parity.
// Latency: first code on the lines the cycle after the handshake; in_rdy only in IDLE or the final SPACE, so words are never queued.
module seq_dualrail_tx #(
  parameter int NBITS  = 8,
  parameter int PARITY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_val,
  output logic             in_rdy,
  output logic             out0,
  output logic             out1
);

  localparam int L  = NBITS + ((PARITY != 0) ? 1 : 0);
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CODE  = 2'd1;
  localparam logic [1:0] S_SPACE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [L-1:0]  sreg, sreg_nxt, load_word;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last;
  logic          take;

  assign last   = (cnt == '0);
  assign in_rdy = (state == S_IDLE) | ((state == S_SPACE) & last);
  assign take   = in_val & in_rdy;

  // Parity sits below the data so it leaves the shifter right after the data LSB.
  generate
    if (PARITY != 0) begin : g_par
      assign load_word = {in_data, ~^in_data};
    end else begin : g_nopar
      assign load_word = in_data;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_nxt = S_CODE;
          sreg_nxt  = load_word;
          cnt_nxt   = CW'(L - 1);
        end
      end
      S_CODE: begin
        state_nxt = S_SPACE;
      end
      S_SPACE: begin
        if (!last) begin
          state_nxt = S_CODE;
          sreg_nxt  = sreg << 1;
          cnt_nxt   = cnt - 1'b1;
        end else if (take) begin
          state_nxt = S_CODE;
          sreg_nxt  = load_word;
          cnt_nxt   = CW'(L - 1);
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Lines are registered from the next-state view so a code appears in the same cycle the FSM sits in CODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out0 <= 1'b0;
      out1 <= 1'b0;
    end else begin
      out1 <= (state_nxt == S_CODE) &  sreg_nxt[L-1];
      out0 <= (state_nxt == S_CODE) & ~sreg_nxt[L-1];
    end
  end

endmodule

// File: tb/tb_seq_dualrail_tx.sv
// Bench for seq_dualrail_tx: a parity instance and a no-parity instance, each checked cycle by cycle against a queue of expected line symbols.
module tb_seq_dualrail_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b;
  logic       rdy_a, o0_a, o1_a;
  logic       rdy_b, o0_b, o1_b;

  int total = 0;
  int bad   = 0;
  int cycles;
  int n;
  bit hs_a, hs_b;
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  always #5 clk = ~clk;

  seq_dualrail_tx #(.NBITS(8), .PARITY(1)) dut_a (
    .clk(clk), .reset(reset), .in_data(data_a), .in_val(val_a),
    .in_rdy(rdy_a), .out0(o0_a), .out1(o1_a)
  );

  seq_dualrail_tx #(.NBITS(8), .PARITY(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(data_b), .in_val(val_b),
    .in_rdy(rdy_b), .out0(o0_b), .out1(o1_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      q_a.push_back(d[i] ? 2'b10 : 2'b01);
      q_a.push_back(2'b00);
    end
    q_a.push_back((~^d) ? 2'b10 : 2'b01);
    q_a.push_back(2'b00);
  endtask

  task automatic push_b(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      q_b.push_back(d[i] ? 2'b10 : 2'b01);
      q_b.push_back(2'b00);
    end
  endtask

  // One clock: decide handshakes from the model's readiness, then check the new cycle's lines and in_rdy.
  task automatic cyc();
    logic [1:0] ea, eb;
    hs_a = val_a && (q_a.size() == 0);
    hs_b = val_b && (q_b.size() == 0);
    @(posedge clk);
    #1;
    if (hs_a) push_a(data_a);
    if (hs_b) push_b(data_b);
    ea = (q_a.size() != 0) ? q_a.pop_front() : 2'b00;
    eb = (q_b.size() != 0) ? q_b.pop_front() : 2'b00;
    chk("line_a", {30'b0, o1_a, o0_a}, {30'b0, ea});
    chk("rdy_a",  {31'b0, rdy_a}, {31'b0, q_a.size() == 0});
    chk("line_b", {30'b0, o1_b, o0_b}, {30'b0, eb});
    chk("rdy_b",  {31'b0, rdy_b}, {31'b0, q_b.size() == 0});
    cycles++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    val_a  = 1'b0;
    val_b  = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;
    #1 reset = 1'b0;
    #1;
    chk("rst_line_a", {30'b0, o1_a, o0_a}, 32'd0);
    chk("rst_rdy_a",  {31'b0, rdy_a}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_line_a2", {30'b0, o1_a, o0_a}, 32'd0);
    chk("rst_rdy_b",   {31'b0, rdy_b}, 32'd1);
    reset = 1'b1;
    repeat (5) cyc();

    // Single word 0xA5 with parity.
    val_a  = 1'b1;
    data_a = 8'hA5;
    cyc();
    val_a = 1'b0;
    repeat (20) cyc();

    // 0x80 then 0xFF back-to-back with in_val held high.
    val_a  = 1'b1;
    data_a = 8'h80;
    cycles = 0;
    cyc();
    data_a = 8'hFF;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!hs_a && n < 40);
    chk("b2b_accept", {31'b0, hs_a}, 32'd1);
    val_a = 1'b0;
    n = 0;
    while (q_a.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    chk("b2b_cycles", cycles, 32'd36);
    repeat (3) cyc();

    // Offer 0x3C mid-frame; it must be ignored.
    val_a  = 1'b1;
    data_a = 8'h11;
    cyc();
    val_a = 1'b0;
    repeat (3) cyc();
    val_a  = 1'b1;
    data_a = 8'h3C;
    cyc();
    chk("midframe_ignored", {31'b0, hs_a}, 32'd0);
    val_a = 1'b0;
    repeat (20) cyc();

    // Reset while the code of bit 3 of 0xF0 is on the lines.
    val_a  = 1'b1;
    data_a = 8'hF0;
    cyc();
    val_a = 1'b0;
    repeat (8) cyc();
    chk("pre_rst_code", {30'b0, o1_a, o0_a}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_line", {30'b0, o1_a, o0_a}, 32'd0);
    chk("midrst_rdy",  {31'b0, rdy_a}, 32'd1);
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    chk("midrst_hold", {30'b0, o1_a, o0_a}, 32'd0);
    reset = 1'b1;
    #1;
    chk("postrst_rdy", {31'b0, rdy_a}, 32'd1);
    val_a  = 1'b1;
    data_a = 8'h01;
    cyc();
    val_a = 1'b0;
    repeat (20) cyc();

    // No-parity instance: 20 random words with random gaps.
    void'($urandom(32'd2024));
    for (int w = 0; w < 20; w++) begin
      repeat ($urandom_range(0, 3)) cyc();
      val_b  = 1'b1;
      data_b = 8'($urandom);
      n = 0;
      do begin
        cyc();
        n++;
      end while (!hs_b && n < 60);
      chk("rand_accept", {31'b0, hs_b}, 32'd1);
      val_b = 1'b0;
    end
    repeat (20) cyc();
    chk("rand_drained", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
